stream_slicer: RTL and testbench
================================

Name: stream_slicer

Overview:
- Sequential serializer that takes one W-bit word per handshake and emits it as a stream of S-bit slices, one slice per accepted output beat.
- Slice order is selectable: MSB-first or LSB-first. A short remainder slice is emitted last when W is not a multiple of S.
- It is the hardware counterpart of the packing/streaming operators. It sits downstream of a word producer and feeds narrow-lane consumers.
- Both sides use valid/ready.

Parameters:
W, 24, input word width in bits; 1 <= S <= W.
S, 7, slice width in bits.
DIR, 0, 0 = MSB-first slicing, 1 = LSB-first slicing.
N (localparam), ceil(W/S), slices per word.
R (localparam), W - (N-1)*S, length of final slice (equals S when W%S==0).
LW (localparam), $clog2(S+1), width of out_len.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
in_data  input  W  input word
out_valid  output  1  slice valid
out_ready  input  1  consumer accepts slice
out_data  output  S  current slice, right-justified; unused upper bits zero
out_len  output  LW  number of valid bits in out_data (S, or R on the last slice)
out_last  output  1  current slice is slice N-1 of the word

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, out_valid=0, out_data=0, out_len=0, out_last=0, slice index=0, holding register=0, in_ready=1 once rst deasserts.
- States:
  - IDLE: no word held; in_ready=1, out_valid=0.
  - EMIT: word held; out_valid=1.
- IDLE -> EMIT on in_valid&&in_ready: capture in_data, index=0.
- Latency: slice 0 is presented with out_valid=1 on the cycle after input acceptance.
- Slice k, for k < N-1:
  - DIR=0: in_data[W-1-k*S -: S].
  - DIR=1: in_data[k*S +: S].
  - out_len=S, out_last=0.
- Slice N-1:
  - DIR=0: in_data[R-1:0].
  - DIR=1: in_data[W-1 -: R].
  - Right-justified; out_len=R, out_last=1.
- Each out_valid&&out_ready beat advances the index by 1.
- Beat on slice N-1 with no new input: return to IDLE, out_valid=0 on the next cycle.
- Back-to-back words: in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - If a new word is accepted in the same cycle the last slice is consumed, stay in EMIT, load the new word, index=0.
  - No bubble cycle.
- Backpressure: while out_valid && !out_ready, out_data, out_len and out_last hold stable. in_ready=0 except in the last-slice case above.
- N=1 (S==W): every word is one slice with out_last=1 and out_len=W. Full throughput of one word per cycle.
- in_valid may drop while in_ready=0 without effect. The block never samples in_data when in_ready=0.
- Reset asserted mid-word: the partial word is discarded. The block returns to IDLE and no further slices of that word are emitted.
- out_data/out_len/out_last are registered (no combinational path from in_data to outputs).
- Width rule: index counter is $clog2(N+1) bits and never exceeds N-1.

Optional Feature:
- Macro: STREAM_SLICER_WCOUNT_EN.
- Defined:
  - Adds output port word_count (16 bits).
  - Reset value 0.
  - Increments on each beat where out_valid&&out_ready&&out_last.
  - Saturates at 16'hFFFF (no wrap).
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
1. W=24,S=7,DIR=0, word 24'h060708, out_ready=1 -> slices 7'h03,7'h01,7'h61,7'h00, out_len 7,7,7,3, out_last only on the 4th; first slice one cycle after accept.
2. W=24,S=7,DIR=1, word 24'h060708 -> slices 7'h08,7'h0E,7'h18,7'h0, last out_len=3.
3. DIR=0, words 24'h060708 then 24'hC02375 with in_valid held high -> second word accepted in the cycle slice 3 of the first is consumed. Eight consecutive out_valid cycles with no gap.
4. out_ready toggled 1,0,0,1,... during word 24'h12E3B8 -> out_data/out_len/out_last stable while stalled; in_ready=0 throughout except the final-slice beat; slice sequence matches the unstalled reference.
5. rst pulsed after 2 slices of 24'h060708 -> out_valid=0 immediately (async). After release, word 24'hC02375 streams from slice 0 with no stale slices.
6. W=8,S=8 (N=1) with continuous 8'hA5,8'h5A -> one slice per cycle, out_last=1, out_len=8. With STREAM_SLICER_WCOUNT_EN, word_count=2 afterwards; a forced 16'hFFFF count stays at 16'hFFFF after one more word.

Source files
------------

// File: rtl/stream_slicer.sv
// Word-to-slice serializer with valid/ready on both sides, MSB- or LSB-first.
// Optional saturating completed-word counter: define STREAM_SLICER_WCOUNT_EN.
module stream_slicer #(
    parameter int W   = 24,
    parameter int S   = 7,
    parameter int DIR = 0,
    localparam int N  = (W + S - 1) / S,
    localparam int R  = W - (N - 1) * S,
    localparam int LW = $clog2(S + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [S-1:0]  out_data,
    output logic [LW-1:0] out_len,
    output logic          out_last
`ifdef STREAM_SLICER_WCOUNT_EN
    ,
    output logic [15:0]   word_count
`endif
);

    localparam int IW = $clog2(N + 1);
    localparam logic [W-1:0] LAST_MASK = {W{1'b1}} >> (W - R);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  hold;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_inc;
    logic          beat, last_beat, accept;
    logic          load, advance;

    // Slice k of a word, right-justified; the final slice is trimmed to R bits.
    function automatic logic [S-1:0] slice_of(input logic [W-1:0] word, input logic [IW-1:0] k);
        logic [W-1:0] sh;
        int unsigned  amt;
        if (DIR == 0)
            amt = (k == IW'(N - 1)) ? 0 : W - (int'(k) + 1) * S;
        else
            amt = int'(k) * S;
        sh = word >> amt;
        if (k == IW'(N - 1))
            sh = sh & LAST_MASK;
        return sh[S-1:0];
    endfunction

    assign out_valid = (state == EMIT);
    assign beat      = out_valid && out_ready;
    assign last_beat = beat && out_last;
    assign in_ready  = (state == IDLE) || last_beat;
    assign accept    = in_valid && in_ready;
    assign idx_inc   = idx + IW'(1);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        advance  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = EMIT;
                    load     = 1'b1;
                end
            end
            EMIT: begin
                // A new word accepted on the last beat reloads without a bubble.
                if (accept)
                    load = 1'b1;
                else if (last_beat)
                    state_nx = IDLE;
                else if (beat)
                    advance = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold     <= '0;
            idx      <= '0;
            out_data <= '0;
            out_len  <= '0;
            out_last <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                hold     <= in_data;
                idx      <= '0;
                out_data <= slice_of(in_data, '0);
                out_len  <= (N == 1) ? LW'(R) : LW'(S);
                out_last <= (N == 1);
            end else if (advance) begin
                idx      <= idx_inc;
                out_data <= slice_of(hold, idx_inc);
                out_len  <= (idx_inc == IW'(N - 1)) ? LW'(R) : LW'(S);
                out_last <= (idx_inc == IW'(N - 1));
            end else if (state_nx == IDLE) begin
                out_data <= '0;
                out_len  <= '0;
                out_last <= 1'b0;
            end
        end
    end

`ifdef STREAM_SLICER_WCOUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            word_count <= '0;
        else if (last_beat && word_count != 16'hFFFF)
            word_count <= word_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_stream_slicer.sv
// Scoreboard bench for stream_slicer: three instances cover MSB-first, LSB-first and N=1.
module tb_stream_slicer;

    typedef struct packed {
        logic [6:0] d;
        logic [2:0] l;
        logic       last;
    } exp_t;

    logic clk, rst;

    logic        iv0, ir0, ov0, or0, olast0;
    logic [23:0] id0;
    logic [6:0]  od0;
    logic [2:0]  ol0;

    logic        iv1, ir1, ov1, or1, olast1;
    logic [23:0] id1;
    logic [6:0]  od1;
    logic [2:0]  ol1;

    logic        iv2, ir2, ov2, or2, olast2;
    logic [7:0]  id2, od2;
    logic [3:0]  ol2;

`ifdef STREAM_SLICER_WCOUNT_EN
    logic [15:0] wc0, wc1, wc2;
`endif

    int passed = 0;
    int total  = 0;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] q2[$];
    int pop0 = 0;
    int run0 = 0, max_run0 = 0;
    int run2 = 0, max_run2 = 0;
    bit stall_en = 0;

    exp_t e_a0[4] = '{'{7'h03, 3'd7, 1'b0}, '{7'h01, 3'd7, 1'b0}, '{7'h61, 3'd7, 1'b0}, '{7'h00, 3'd3, 1'b1}};
    exp_t e_a1[4] = '{'{7'h08, 3'd7, 1'b0}, '{7'h0E, 3'd7, 1'b0}, '{7'h18, 3'd7, 1'b0}, '{7'h00, 3'd3, 1'b1}};
    exp_t e_b0[4] = '{'{7'h60, 3'd7, 1'b0}, '{7'h08, 3'd7, 1'b0}, '{7'h6E, 3'd7, 1'b0}, '{7'h05, 3'd3, 1'b1}};
    exp_t e_c0[4] = '{'{7'h09, 3'd7, 1'b0}, '{7'h38, 3'd7, 1'b0}, '{7'h77, 3'd7, 1'b0}, '{7'h00, 3'd3, 1'b1}};

    stream_slicer #(.W(24), .S(7), .DIR(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_len(ol0), .out_last(olast0)
`ifdef STREAM_SLICER_WCOUNT_EN
        , .word_count(wc0)
`endif
    );

    stream_slicer #(.W(24), .S(7), .DIR(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_len(ol1), .out_last(olast1)
`ifdef STREAM_SLICER_WCOUNT_EN
        , .word_count(wc1)
`endif
    );

    stream_slicer #(.W(8), .S(8), .DIR(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_len(ol2), .out_last(olast2)
`ifdef STREAM_SLICER_WCOUNT_EN
        , .word_count(wc2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s: condition not met", name);
    endtask

    // Monitor for dut0: scoreboard pop, stall stability and in_ready rule.
    exp_t pe;
    bit   prev_stall = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 0;
            run0 = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", ov0, 1);
                check("stall_data", od0, pe.d);
                check("stall_len", ol0, pe.l);
                check("stall_last", olast0, pe.last);
            end
            if (ov0) begin
                if (!or0) check("in_ready_stalled", ir0, 0);
                else begin
                    check("in_ready_beat", ir0, olast0);
                    if (q0.size() == 0) fail("unexpected_slice0");
                    else begin
                        e = q0.pop_front();
                        check("slice0_data", od0, e.d);
                        check("slice0_len", ol0, e.l);
                        check("slice0_last", olast0, e.last);
                        pop0++;
                    end
                end
                run0++;
                if (run0 > max_run0) max_run0 = run0;
            end else run0 = 0;
            prev_stall = ov0 && !or0;
            pe = '{od0, ol0, olast0};
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov1 && or1) begin
            if (q1.size() == 0) fail("unexpected_slice1");
            else begin
                e = q1.pop_front();
                check("slice1_data", od1, e.d);
                check("slice1_len", ol1, e.l);
                check("slice1_last", olast1, e.last);
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) run2 = 0;
        else begin
            if (ov2 && or2) begin
                if (q2.size() == 0) fail("unexpected_slice2");
                else begin
                    e = q2.pop_front();
                    check("slice2_data", od2, e);
                    check("slice2_len", ol2, 8);
                    check("slice2_last", olast2, 1);
                end
            end
            if (ov2) begin
                run2++;
                if (run2 > max_run2) max_run2 = run2;
            end else run2 = 0;
        end
    end

    // Drives out_ready of dut0: always ready, or the 1,0,0,1 stall pattern.
    initial begin
        int ph = 0;
        or0 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en) begin
                or0 = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                or0 = 1'b1;
                ph = 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send0(input logic [23:0] w, input exp_t e[4], input bit hold);
        bit acc = 0;
        iv0 = 1'b1;
        id0 = w;
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            acc = ir0;
            @(posedge clk);
            #1;
        end
        if (!acc) fail("accept_timeout0");
        else for (int k = 0; k < 4; k++) q0.push_back(e[k]);
        if (!hold) iv0 = 1'b0;
    endtask

    task automatic drain0();
        bit done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (q0.size() == 0 && !ov0) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) fail("drain_timeout0");
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        bit done;
        int base;
        rst = 1'b1;
        iv0 = 0; id0 = '0;
        iv1 = 0; id1 = '0; or1 = 1'b1;
        iv2 = 0; id2 = '0; or2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", ov0, 0);
        check("rst_out_data", od0, 0);
        check("rst_out_len", ol0, 0);
        check("rst_out_last", olast0, 0);
        rst = 1'b0;
        step();
        check("idle_in_ready", ir0, 1);

        // MSB-first single word with first-slice latency
        send0(24'h060708, e_a0, 0);
        @(negedge clk);
        check("first_slice_latency", ov0, 1);
        step();
        drain0();

        // LSB-first single word on dut1
        iv1 = 1'b1;
        id1 = 24'h060708;
        @(negedge clk);
        acc = ir1;
        step();
        iv1 = 1'b0;
        check("dir1_accept", acc, 1);
        for (int k = 0; k < 4; k++) q1.push_back(e_a1[k]);
        done = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            if (q1.size() == 0 && !ov1) done = 1;
            else step();
        end
        if (!done) fail("drain_timeout1");

        // Back-to-back words with in_valid held high
        max_run0 = 0;
        send0(24'h060708, e_a0, 1);
        send0(24'hC02375, e_b0, 0);
        drain0();
        check("no_bubble_run", max_run0, 8);

        // Backpressure
        stall_en = 1;
        send0(24'h12E3B8, e_c0, 0);
        drain0();
        stall_en = 0;
        step();

        // Async reset after two slices, then a fresh word
        base = pop0;
        send0(24'h060708, e_a0, 0);
        done = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            if (pop0 >= base + 2) done = 1;
            else step();
        end
        if (!done) fail("two_slices_timeout");
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", ov0, 0);
        check("async_rst_data", od0, 0);
        q0.delete();
        step();
        rst = 1'b0;
        step();
        check("post_rst_valid", ov0, 0);
        send0(24'hC02375, e_b0, 0);
        drain0();

        // N=1 continuous words
        max_run2 = 0;
        iv2 = 1'b1;
        id2 = 8'hA5;
        @(negedge clk);
        acc = ir2;
        step();
        check("n1_accept_a5", acc, 1);
        q2.push_back(8'hA5);
        id2 = 8'h5A;
        @(negedge clk);
        acc = ir2;
        step();
        check("n1_accept_5a", acc, 1);
        q2.push_back(8'h5A);
        iv2 = 1'b0;
        repeat (3) step();
        check("n1_queue_empty", q2.size(), 0);
        check("n1_throughput_run", max_run2, 2);
`ifdef STREAM_SLICER_WCOUNT_EN
        check("word_count_two", wc2, 16'd2);
        force dut2.word_count = 16'hFFFF;
        #1;
        release dut2.word_count;
        iv2 = 1'b1;
        id2 = 8'h3C;
        @(negedge clk);
        acc = ir2;
        step();
        iv2 = 1'b0;
        check("n1_accept_3c", acc, 1);
        q2.push_back(8'h3C);
        repeat (3) step();
        check("word_count_saturate", wc2, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
